// File: rtl/npc_axi_xbar_pkg.sv
// Shared encodings for the NPC AXI crossbar: response codes, FSM states, target selects, CLINT window.
package npc_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_REQ  = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  typedef enum logic [1:0] {
    SEL_EXT   = 2'd0,
    SEL_CLINT = 2'd1,
    SEL_ERR   = 2'd2
  } sel_t;

  localparam logic [31:0] CLINT_BASE_DEF = 32'h0200_0000;
  localparam logic [31:0] CLINT_SIZE_DEF = 32'h0001_0000;

endpackage

// File: rtl/npc_axi_xbar_if.sv
// Full AXI4 five-channel bundle; master drives requests, slave drives responses.
interface npc_axi_if;

  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bresp, bid, output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst, input arready,
    input  rvalid, rdata, rresp, rid, rlast, output rready
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bresp, bid, input bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst, output arready,
    output rvalid, rdata, rresp, rid, rlast, input rready
  );

endinterface

// File: rtl/npc_axi_xbar_decode.sv
// Address-to-target decode, purely combinational; NPC_XBAR_DECERR_EN adds the unmapped-hole check.
module npc_xbar_decode
  import npc_axi_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = CLINT_BASE_DEF,
  parameter logic [31:0] CLINT_SIZE = CLINT_SIZE_DEF
`ifdef NPC_XBAR_DECERR_EN
  ,
  parameter logic [31:0] EXT_LO = 32'h0F00_0000,
  parameter logic [31:0] EXT_HI = 32'hFFFF_FFFF
`endif
) (
  input  logic [31:0] addr,
  output sel_t        sel
);

  // Subtract-then-compare keeps the window check a single unsigned compare with wraparound.
  logic [31:0] offset;
  assign offset = addr - CLINT_BASE;

  always_comb begin
    sel = SEL_EXT;
    if (offset < CLINT_SIZE) sel = SEL_CLINT;
`ifdef NPC_XBAR_DECERR_EN
    else if ((addr < EXT_LO) || (addr > EXT_HI)) sel = SEL_ERR;
`endif
  end

endmodule

// File: rtl/npc_axi_xbar.sv
// 1-master/2-slave AXI4 crossbar (CLINT window -> clint, else -> ext); NPC_XBAR_DECERR_EN adds a DECERR slave.
// One read + one write outstanding, 1-cycle decode bubble on AR/AW; data and responses pass through combinationally.
module npc_axi_xbar
  import npc_axi_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = CLINT_BASE_DEF,
  parameter logic [31:0] CLINT_SIZE = CLINT_SIZE_DEF,
  parameter logic [31:0] EXT_LO     = 32'h0F00_0000,
  parameter logic [31:0] EXT_HI     = 32'hFFFF_FFFF
) (
  input logic      clock,
  input logic      reset,
  npc_axi_if.slave  m,
  npc_axi_if.master ext,
  npc_axi_if.master clint
);

  sel_t ar_sel, aw_sel, sel_r, sel_w;
  logic [1:0] r_state, w_state;
  logic aw_done, w_done;
`ifdef NPC_XBAR_DECERR_EN
  logic [3:0] r_id, w_id;
  logic [7:0] r_len, beat_cnt;
`endif

`ifdef NPC_XBAR_DECERR_EN
  npc_xbar_decode #(.CLINT_BASE(CLINT_BASE), .CLINT_SIZE(CLINT_SIZE), .EXT_LO(EXT_LO), .EXT_HI(EXT_HI))
    u_ar_dec (.addr(m.araddr), .sel(ar_sel));
  npc_xbar_decode #(.CLINT_BASE(CLINT_BASE), .CLINT_SIZE(CLINT_SIZE), .EXT_LO(EXT_LO), .EXT_HI(EXT_HI))
    u_aw_dec (.addr(m.awaddr), .sel(aw_sel));
`else
  npc_xbar_decode #(.CLINT_BASE(CLINT_BASE), .CLINT_SIZE(CLINT_SIZE)) u_ar_dec (.addr(m.araddr), .sel(ar_sel));
  npc_xbar_decode #(.CLINT_BASE(CLINT_BASE), .CLINT_SIZE(CLINT_SIZE)) u_aw_dec (.addr(m.awaddr), .sel(aw_sel));
`endif

  logic r_addr_st, r_data_st, w_req_st, w_resp_st;
  assign r_addr_st = (r_state == R_ADDR);
  assign r_data_st = (r_state == R_DATA);
  assign w_req_st  = (w_state == W_REQ);
  assign w_resp_st = (w_state == W_RESP);

  assign ext.araddr   = m.araddr;   assign clint.araddr  = m.araddr;
  assign ext.arid     = m.arid;     assign clint.arid    = m.arid;
  assign ext.arlen    = m.arlen;    assign clint.arlen   = m.arlen;
  assign ext.arsize   = m.arsize;   assign clint.arsize  = m.arsize;
  assign ext.arburst  = m.arburst;  assign clint.arburst = m.arburst;
  assign ext.awaddr   = m.awaddr;   assign clint.awaddr  = m.awaddr;
  assign ext.awid     = m.awid;     assign clint.awid    = m.awid;
  assign ext.awlen    = m.awlen;    assign clint.awlen   = m.awlen;
  assign ext.awsize   = m.awsize;   assign clint.awsize  = m.awsize;
  assign ext.awburst  = m.awburst;  assign clint.awburst = m.awburst;
  assign ext.wdata    = m.wdata;    assign clint.wdata   = m.wdata;
  assign ext.wstrb    = m.wstrb;    assign clint.wstrb   = m.wstrb;
  assign ext.wlast    = m.wlast;    assign clint.wlast   = m.wlast;

  // Only the latched target ever sees a valid or ready; the other port stays quiet.
  assign ext.arvalid   = r_addr_st && (sel_r == SEL_EXT)   && m.arvalid;
  assign clint.arvalid = r_addr_st && (sel_r == SEL_CLINT) && m.arvalid;
  assign ext.rready    = r_data_st && (sel_r == SEL_EXT)   && m.rready;
  assign clint.rready  = r_data_st && (sel_r == SEL_CLINT) && m.rready;
  assign ext.awvalid   = w_req_st  && (sel_w == SEL_EXT)   && !aw_done && m.awvalid;
  assign clint.awvalid = w_req_st  && (sel_w == SEL_CLINT) && !aw_done && m.awvalid;
  assign ext.wvalid    = w_req_st  && (sel_w == SEL_EXT)   && !w_done  && m.wvalid;
  assign clint.wvalid  = w_req_st  && (sel_w == SEL_CLINT) && !w_done  && m.wvalid;
  assign ext.bready    = w_resp_st && (sel_w == SEL_EXT)   && m.bready;
  assign clint.bready  = w_resp_st && (sel_w == SEL_CLINT) && m.bready;

  always_comb begin
    m.arready = r_addr_st && ext.arready;
    m.rvalid  = r_data_st && ext.rvalid;
    m.rdata   = ext.rdata;
    m.rresp   = ext.rresp;
    m.rid     = ext.rid;
    m.rlast   = ext.rlast;
    case (sel_r)
      SEL_CLINT: begin
        m.arready = r_addr_st && clint.arready;
        m.rvalid  = r_data_st && clint.rvalid;
        m.rdata   = clint.rdata;
        m.rresp   = clint.rresp;
        m.rid     = clint.rid;
        m.rlast   = clint.rlast;
      end
`ifdef NPC_XBAR_DECERR_EN
      SEL_ERR: begin
        m.arready = r_addr_st;
        m.rvalid  = r_data_st;
        m.rdata   = '0;
        m.rresp   = RESP_DECERR;
        m.rid     = r_id;
        m.rlast   = (beat_cnt == r_len);
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    m.awready = w_req_st && !aw_done && ext.awready;
    m.wready  = w_req_st && !w_done  && ext.wready;
    m.bvalid  = w_resp_st && ext.bvalid;
    m.bresp   = ext.bresp;
    m.bid     = ext.bid;
    case (sel_w)
      SEL_CLINT: begin
        m.awready = w_req_st && !aw_done && clint.awready;
        m.wready  = w_req_st && !w_done  && clint.wready;
        m.bvalid  = w_resp_st && clint.bvalid;
        m.bresp   = clint.bresp;
        m.bid     = clint.bid;
      end
`ifdef NPC_XBAR_DECERR_EN
      SEL_ERR: begin
        m.awready = w_req_st && !aw_done;
        m.wready  = w_req_st && !w_done;
        m.bvalid  = w_resp_st;
        m.bresp   = RESP_DECERR;
        m.bid     = w_id;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= R_IDLE;
      sel_r    <= SEL_EXT;
`ifdef NPC_XBAR_DECERR_EN
      r_id     <= '0;
      r_len    <= '0;
      beat_cnt <= '0;
`endif
    end else begin
      case (r_state)
        R_IDLE: if (m.arvalid) begin
          sel_r    <= ar_sel;
`ifdef NPC_XBAR_DECERR_EN
          r_id     <= m.arid;
          r_len    <= m.arlen;
          beat_cnt <= '0;
`endif
          r_state  <= R_ADDR;
        end
        R_ADDR: if (m.arvalid && m.arready) r_state <= R_DATA;
        R_DATA: if (m.rvalid && m.rready) begin
`ifdef NPC_XBAR_DECERR_EN
          beat_cnt <= beat_cnt + 8'd1;
`endif
          if (m.rlast) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // AW and W may complete in either order or together; both flags gate the move to W_RESP.
  logic aw_done_nxt, w_done_nxt;
  assign aw_done_nxt = aw_done || (m.awvalid && m.awready);
  assign w_done_nxt  = w_done  || (m.wvalid && m.wready && m.wlast);

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state <= W_IDLE;
      sel_w   <= SEL_EXT;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
`ifdef NPC_XBAR_DECERR_EN
      w_id    <= '0;
`endif
    end else begin
      case (w_state)
        W_IDLE: if (m.awvalid) begin
          sel_w   <= aw_sel;
`ifdef NPC_XBAR_DECERR_EN
          w_id    <= m.awid;
`endif
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          w_state <= W_REQ;
        end
        W_REQ: begin
          aw_done <= aw_done_nxt;
          w_done  <= w_done_nxt;
          if (aw_done_nxt && w_done_nxt) w_state <= W_RESP;
        end
        W_RESP: if (m.bvalid && m.bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_npc_axi_xbar.sv
// Directed bench for npc_axi_xbar: stimulus applied on the falling edge, outputs sampled 1ns later.
module tb_npc_axi_xbar;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  npc_axi_if m_if();
  npc_axi_if ext_if();
  npc_axi_if clint_if();

  npc_axi_xbar dut (.clock(clock), .reset(reset), .m(m_if), .ext(ext_if), .clint(clint_if));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic idle_all;
    m_if.awvalid = 0; m_if.awaddr = 0; m_if.awid = 0; m_if.awlen = 0; m_if.awsize = 3'd2; m_if.awburst = 2'b01;
    m_if.wvalid = 0; m_if.wdata = 0; m_if.wstrb = 0; m_if.wlast = 0; m_if.bready = 0;
    m_if.arvalid = 0; m_if.araddr = 0; m_if.arid = 0; m_if.arlen = 0; m_if.arsize = 3'd2; m_if.arburst = 2'b01;
    m_if.rready = 0;
    ext_if.awready = 0; ext_if.wready = 0; ext_if.bvalid = 0; ext_if.bresp = 0; ext_if.bid = 0;
    ext_if.arready = 0; ext_if.rvalid = 0; ext_if.rdata = 0; ext_if.rresp = 0; ext_if.rid = 0; ext_if.rlast = 0;
    clint_if.awready = 0; clint_if.wready = 0; clint_if.bvalid = 0; clint_if.bresp = 0; clint_if.bid = 0;
    clint_if.arready = 0; clint_if.rvalid = 0; clint_if.rdata = 0; clint_if.rresp = 0; clint_if.rid = 0; clint_if.rlast = 0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_all();
    m_if.arvalid = 1; m_if.awvalid = 1; m_if.wvalid = 1;
    ext_if.arready = 1; ext_if.awready = 1; ext_if.wready = 1; ext_if.rvalid = 1; ext_if.bvalid = 1;
    repeat (2) @(negedge clock);
    #1;
    n_chk++; if (m_if.arready !== 1'b0) begin n_fail++; $display("FAIL reset_arready: got %b want 0", m_if.arready); end
    n_chk++; if (m_if.awready !== 1'b0 || m_if.wready !== 1'b0) begin n_fail++; $display("FAIL reset_aw_w_ready: got %b%b want 00", m_if.awready, m_if.wready); end
    n_chk++; if (m_if.rvalid !== 1'b0 || m_if.bvalid !== 1'b0) begin n_fail++; $display("FAIL reset_r_b_valid: got %b%b want 00", m_if.rvalid, m_if.bvalid); end
    n_chk++; if ({ext_if.arvalid, ext_if.awvalid, clint_if.arvalid, clint_if.awvalid} !== 4'b0) begin n_fail++; $display("FAIL reset_slave_valids: got %b want 0000", {ext_if.arvalid, ext_if.awvalid, clint_if.arvalid, clint_if.awvalid}); end
    @(negedge clock);
    idle_all();
    reset = 1'b0;
    // W with no AW: held off in W_IDLE
    m_if.wvalid = 1; m_if.wlast = 1; ext_if.wready = 1;
    repeat (2) begin
      @(negedge clock); #1;
      n_chk++; if (m_if.wready !== 1'b0 || ext_if.wvalid !== 1'b0) begin n_fail++; $display("FAIL w_before_aw: got wready=%b ext_wvalid=%b want 0 0", m_if.wready, ext_if.wvalid); end
    end
    @(negedge clock); idle_all();
  endtask

  task automatic test_read_ext;
    m_if.arvalid = 1; m_if.araddr = 32'h8000_0000; m_if.arid = 4'd5; m_if.arlen = 0;
    ext_if.arready = 1; clint_if.arready = 1;
    #1;
    n_chk++; if (ext_if.arvalid !== 1'b0 || m_if.arready !== 1'b0) begin n_fail++; $display("FAIL rd_ext_bubble: got arvalid=%b arready=%b want 0 0", ext_if.arvalid, m_if.arready); end
    @(negedge clock); #1;
    n_chk++; if ({ext_if.arvalid, clint_if.arvalid, m_if.arready} !== 3'b101) begin n_fail++; $display("FAIL rd_ext_addr: got ext/clint/mready=%b want 101", {ext_if.arvalid, clint_if.arvalid, m_if.arready}); end
    @(negedge clock);
    m_if.arvalid = 0; m_if.rready = 1;
    ext_if.rvalid = 1; ext_if.rdata = 32'hCAFE_0001; ext_if.rresp = 2'b00; ext_if.rid = 4'd5; ext_if.rlast = 1;
    #1;
    n_chk++; if (m_if.rvalid !== 1'b1 || m_if.rdata !== 32'hCAFE_0001 || m_if.rlast !== 1'b1) begin n_fail++; $display("FAIL rd_ext_data: got v=%b d=%h l=%b want 1 cafe0001 1", m_if.rvalid, m_if.rdata, m_if.rlast); end
    n_chk++; if (ext_if.rready !== 1'b1 || clint_if.rready !== 1'b0) begin n_fail++; $display("FAIL rd_ext_rready: got ext=%b clint=%b want 1 0", ext_if.rready, clint_if.rready); end
    @(negedge clock); #1;
    n_chk++; if (m_if.rvalid !== 1'b0 || ext_if.rready !== 1'b0) begin n_fail++; $display("FAIL rd_ext_idle: got rvalid=%b rready=%b want 0 0", m_if.rvalid, ext_if.rready); end
    @(negedge clock); idle_all();
  endtask

  task automatic test_write_clint;
    m_if.awvalid = 1; m_if.awaddr = 32'h0200_BFF8; m_if.awid = 4'd3;
    m_if.wvalid = 1; m_if.wdata = 32'h1234_5678; m_if.wstrb = 4'hF; m_if.wlast = 1;
    clint_if.awready = 1; clint_if.wready = 1; ext_if.awready = 1; ext_if.wready = 1;
    @(negedge clock); #1;
    n_chk++; if ({clint_if.awvalid, clint_if.wvalid, ext_if.awvalid, ext_if.wvalid} !== 4'b1100) begin n_fail++; $display("FAIL wr_clint_route: got clint aw/w ext aw/w=%b want 1100", {clint_if.awvalid, clint_if.wvalid, ext_if.awvalid, ext_if.wvalid}); end
    n_chk++; if (clint_if.wdata !== 32'h1234_5678 || clint_if.wstrb !== 4'hF) begin n_fail++; $display("FAIL wr_clint_wdata: got %h/%h want 12345678/f", clint_if.wdata, clint_if.wstrb); end
    @(negedge clock);
    m_if.awvalid = 0; m_if.wvalid = 0; m_if.bready = 1;
    clint_if.bvalid = 1; clint_if.bresp = 2'b00; clint_if.bid = 4'd3;
    #1;
    n_chk++; if (m_if.bvalid !== 1'b1 || m_if.bresp !== 2'b00 || m_if.bid !== 4'd3) begin n_fail++; $display("FAIL wr_clint_b: got v=%b resp=%b id=%h want 1 00 3", m_if.bvalid, m_if.bresp, m_if.bid); end
    n_chk++; if (clint_if.bready !== 1'b1 || ext_if.bready !== 1'b0) begin n_fail++; $display("FAIL wr_clint_bready: got clint=%b ext=%b want 1 0", clint_if.bready, ext_if.bready); end
    @(negedge clock); #1;
    n_chk++; if (m_if.bvalid !== 1'b0) begin n_fail++; $display("FAIL wr_clint_idle: got bvalid=%b want 0", m_if.bvalid); end
    @(negedge clock); idle_all();
  endtask

  task automatic test_read_burst;
    int k = 0;
    m_if.arvalid = 1; m_if.araddr = 32'h8000_0100; m_if.arid = 4'd2; m_if.arlen = 8'd3;
    ext_if.arready = 1;
    repeat (2) @(negedge clock);
    m_if.arvalid = 0;
    for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
      if (cyc != 0) @(negedge clock);
      m_if.rready = (cyc % 2 == 0);
      ext_if.rvalid = 1; ext_if.rid = 4'd2; ext_if.rdata = 32'hB000_0000 + k; ext_if.rlast = (k == 3);
      #1;
      if (!m_if.rready) begin
        n_chk++; if (ext_if.rready !== 1'b0) begin n_fail++; $display("FAIL burst_stall_rready: got %b want 0", ext_if.rready); end
      end else if (m_if.rvalid) begin
        n_chk++; if (m_if.rdata !== 32'hB000_0000 + k) begin n_fail++; $display("FAIL burst_data%0d: got %h want %h", k, m_if.rdata, 32'hB000_0000 + k); end
        n_chk++; if (m_if.rlast !== (k == 3)) begin n_fail++; $display("FAIL burst_last%0d: got %b want %b", k, m_if.rlast, (k == 3)); end
        k++;
      end
    end
    n_chk++; if (k != 4) begin n_fail++; $display("FAIL burst_beats: got %0d want 4", k); end
    @(negedge clock); #1;
    n_chk++; if (m_if.rvalid !== 1'b0) begin n_fail++; $display("FAIL burst_idle: got rvalid=%b want 0", m_if.rvalid); end
    @(negedge clock); idle_all();
  endtask

  task automatic test_concurrent;
    m_if.arvalid = 1; m_if.araddr = 32'h0200_4000; m_if.arid = 4'd1; m_if.arlen = 0;
    m_if.awvalid = 1; m_if.awaddr = 32'h8000_0040; m_if.awid = 4'd6;
    m_if.wvalid = 1; m_if.wdata = 32'hA5A5_0000; m_if.wstrb = 4'hF; m_if.wlast = 1;
    clint_if.arready = 1; ext_if.awready = 1; ext_if.wready = 1;
    @(negedge clock); #1;
    n_chk++; if ({clint_if.arvalid, ext_if.arvalid} !== 2'b10) begin n_fail++; $display("FAIL conc_ar_route: got clint/ext=%b want 10", {clint_if.arvalid, ext_if.arvalid}); end
    n_chk++; if ({ext_if.awvalid, ext_if.wvalid, clint_if.awvalid, clint_if.wvalid} !== 4'b1100) begin n_fail++; $display("FAIL conc_aw_route: got ext aw/w clint aw/w=%b want 1100", {ext_if.awvalid, ext_if.wvalid, clint_if.awvalid, clint_if.wvalid}); end
    @(negedge clock);
    m_if.arvalid = 0; m_if.awvalid = 0; m_if.wvalid = 0; m_if.rready = 1; m_if.bready = 1;
    clint_if.rvalid = 1; clint_if.rdata = 32'hC1C1_0000; clint_if.rid = 4'd1; clint_if.rlast = 1;
    ext_if.bvalid = 1; ext_if.bid = 4'd6; ext_if.bresp = 2'b00;
    #1;
    n_chk++; if (m_if.rvalid !== 1'b1 || m_if.rdata !== 32'hC1C1_0000 || {clint_if.rready, ext_if.rready} !== 2'b10) begin n_fail++; $display("FAIL conc_r: got v=%b d=%h rready clint/ext=%b want 1 c1c10000 10", m_if.rvalid, m_if.rdata, {clint_if.rready, ext_if.rready}); end
    n_chk++; if (m_if.bvalid !== 1'b1 || m_if.bid !== 4'd6 || {ext_if.bready, clint_if.bready} !== 2'b10) begin n_fail++; $display("FAIL conc_b: got v=%b id=%h bready ext/clint=%b want 1 6 10", m_if.bvalid, m_if.bid, {ext_if.bready, clint_if.bready}); end
    @(negedge clock); #1;
    n_chk++; if (m_if.rvalid !== 1'b0 || m_if.bvalid !== 1'b0) begin n_fail++; $display("FAIL conc_idle: got r/b valid=%b%b want 00", m_if.rvalid, m_if.bvalid); end
    @(negedge clock); idle_all();
  endtask

  // w_delay = 0: AW and W together; otherwise W arrives w_delay cycles after the AW handshake.
  task automatic test_write_timing(input int w_delay, input int b_cyc);
    int nb = 0;
    int at = -1;
    ext_if.awready = 1; ext_if.wready = 1; ext_if.bvalid = 1; ext_if.bid = 4'd7; m_if.bready = 1;
    m_if.awaddr = 32'h8000_0200; m_if.awid = 4'd7; m_if.wdata = 32'h0BAD_F00D; m_if.wstrb = 4'hF; m_if.wlast = 1;
    for (int cyc = 0; cyc < 9; cyc++) begin
      if (cyc != 0) @(negedge clock);
      m_if.awvalid = (w_delay == 0) ? (cyc <= 1) : (cyc <= 2);
      m_if.wvalid  = (w_delay == 0) ? (cyc <= 1) : (cyc == 1 + w_delay);
      #1;
      if (cyc == 1) begin
        n_chk++; if (m_if.awready !== 1'b1) begin n_fail++; $display("FAIL wt%0d_awready: got %b want 1", w_delay, m_if.awready); end
      end
      if (cyc == 2 && w_delay != 0) begin
        n_chk++; if (m_if.awready !== 1'b0 || ext_if.awvalid !== 1'b0) begin n_fail++; $display("FAIL wt%0d_aw_done: got awready=%b ext_awvalid=%b want 0 0", w_delay, m_if.awready, ext_if.awvalid); end
      end
      if (m_if.bvalid && m_if.bready) begin nb++; at = cyc; end
    end
    n_chk++; if (nb != 1 || at != b_cyc) begin n_fail++; $display("FAIL wt%0d_b: got %0d handshakes at cycle %0d want 1 at %0d", w_delay, nb, at, b_cyc); end
    @(negedge clock); idle_all();
  endtask

  task automatic test_reset_midburst;
    m_if.arvalid = 1; m_if.araddr = 32'h8000_0300; m_if.arlen = 8'd3; ext_if.arready = 1;
    repeat (2) @(negedge clock);
    m_if.arvalid = 0; m_if.rready = 1; ext_if.rvalid = 1; ext_if.rlast = 0;
    #1;
    n_chk++; if (m_if.rvalid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got rvalid=%b want 1", m_if.rvalid); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_chk++; if (m_if.rvalid !== 1'b0 || ext_if.rready !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got rvalid=%b rready=%b want 0 0", m_if.rvalid, ext_if.rready); end
    @(negedge clock); idle_all();
  endtask

  task automatic test_unmapped;
    m_if.arvalid = 1; m_if.araddr = 32'h0000_1000; m_if.arid = 4'd9; m_if.arlen = 8'd1;
    ext_if.arready = 1;
    @(negedge clock); #1;
`ifdef NPC_XBAR_DECERR_EN
    n_chk++; if ({m_if.arready, ext_if.arvalid, clint_if.arvalid} !== 3'b100) begin n_fail++; $display("FAIL decerr_ar: got mready/ext/clint=%b want 100", {m_if.arready, ext_if.arvalid, clint_if.arvalid}); end
    @(negedge clock);
    m_if.arvalid = 0; m_if.rready = 1; ext_if.rvalid = 1; ext_if.rdata = 32'hFFFF_FFFF;
    for (int b = 0; b < 2; b++) begin
      if (b != 0) @(negedge clock);
      #1;
      n_chk++; if ({m_if.rvalid, m_if.rresp, m_if.rid, m_if.rlast} !== {1'b1, 2'b11, 4'd9, (b == 1)} || m_if.rdata !== 32'h0) begin n_fail++; $display("FAIL decerr_r%0d: got v=%b resp=%b id=%h last=%b d=%h want 1 11 9 %0d 0", b, m_if.rvalid, m_if.rresp, m_if.rid, m_if.rlast, m_if.rdata, b); end
      n_chk++; if (ext_if.rready !== 1'b0 || clint_if.rready !== 1'b0) begin n_fail++; $display("FAIL decerr_rready%0d: got ext=%b clint=%b want 0 0", b, ext_if.rready, clint_if.rready); end
    end
    @(negedge clock); #1;
    n_chk++; if (m_if.rvalid !== 1'b0) begin n_fail++; $display("FAIL decerr_idle: got rvalid=%b want 0", m_if.rvalid); end
    @(negedge clock); idle_all();
    m_if.awvalid = 1; m_if.awaddr = 32'h0000_2000; m_if.awid = 4'd4; m_if.wvalid = 1; m_if.wlast = 1; m_if.bready = 1;
    @(negedge clock); #1;
    n_chk++; if ({m_if.awready, m_if.wready, ext_if.awvalid, ext_if.wvalid} !== 4'b1100) begin n_fail++; $display("FAIL decerr_aw: got aw/w ready ext aw/w=%b want 1100", {m_if.awready, m_if.wready, ext_if.awvalid, ext_if.wvalid}); end
    @(negedge clock);
    m_if.awvalid = 0; m_if.wvalid = 0;
    #1;
    n_chk++; if ({m_if.bvalid, m_if.bresp, m_if.bid} !== {1'b1, 2'b11, 4'd4}) begin n_fail++; $display("FAIL decerr_b: got v=%b resp=%b id=%h want 1 11 4", m_if.bvalid, m_if.bresp, m_if.bid); end
`else
    n_chk++; if ({ext_if.arvalid, clint_if.arvalid, m_if.arready} !== 3'b101) begin n_fail++; $display("FAIL hole_to_ext: got ext/clint/mready=%b want 101", {ext_if.arvalid, clint_if.arvalid, m_if.arready}); end
    @(negedge clock);
    m_if.arvalid = 0; m_if.rready = 1;
    for (int b = 0; b < 2; b++) begin
      if (b != 0) @(negedge clock);
      ext_if.rvalid = 1; ext_if.rdata = 32'hD000_0000 + b; ext_if.rid = 4'd9; ext_if.rlast = (b == 1);
      #1;
      n_chk++; if (m_if.rdata !== 32'hD000_0000 + b || m_if.rresp !== 2'b00 || m_if.rlast !== (b == 1)) begin n_fail++; $display("FAIL hole_r%0d: got d=%h resp=%b last=%b want %h 00 %0d", b, m_if.rdata, m_if.rresp, m_if.rlast, 32'hD000_0000 + b, b); end
    end
    @(negedge clock); #1;
    n_chk++; if (m_if.rvalid !== 1'b0) begin n_fail++; $display("FAIL hole_idle: got rvalid=%b want 0", m_if.rvalid); end
`endif
    @(negedge clock); idle_all();
  endtask

  initial begin
    test_reset();
    @(negedge clock); test_read_ext();
    @(negedge clock); test_write_clint();
    @(negedge clock); test_read_burst();
    @(negedge clock); test_concurrent();
    @(negedge clock); test_write_timing(0, 2);
    @(negedge clock); test_write_timing(3, 5);
    @(negedge clock); test_reset_midburst();
    @(negedge clock); test_unmapped();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
